// File: rtl/muldiv_32b.sv
`default_nettype none
// ============================================================================
// muldiv_32b : iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Revision   : 1.0
// ============================================================================
module muldiv_32b (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] mcand_q, mcand_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        w_signed;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] w_mul_sum;
   logic [32:0] w_rem_sh;
   logic [33:0] w_div_sub;
   logic [63:0] w_prod_neg;

   // A zero divisor runs unsigned so the restoring loop itself yields
   // rem = A and quot = all ones, with no sign correction afterwards.
   assign w_signed   = op[0] & ~(op[1] & (B == 32'd0));
   assign w_a_mag    = (w_signed && A[31]) ? (~A + 32'd1) : A;
   assign w_b_mag    = (w_signed && B[31]) ? (~B + 32'd1) : B;
   assign w_mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
   assign w_rem_sh   = acc_q[63:31];
   assign w_div_sub  = {1'b0, w_rem_sh} - {2'b00, mcand_q};
   assign w_prod_neg = ~acc_q + 64'd1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               cnt_d    = 6'd0;
               is_div_d = op[1];
               if (op[1]) begin
                  neg_res_d = w_signed & (A[31] ^ B[31]);
                  neg_rem_d = w_signed & A[31];
                  mcand_d   = w_b_mag;
                  acc_d     = {32'd0, w_a_mag};
               end else begin
                  neg_res_d = w_signed & (A[31] ^ B[31]);
                  neg_rem_d = 1'b0;
                  mcand_d   = w_a_mag;
                  acc_d     = {32'd0, w_b_mag};
               end
            end
         end

         S_RUN: begin
            if (is_div_q) begin
               if (!w_div_sub[33]) begin
                  acc_d = {w_div_sub[31:0], acc_q[30:0], 1'b1};
               end else begin
                  acc_d = {w_rem_sh[31:0], acc_q[30:0], 1'b0};
               end
            end else begin
               acc_d = {w_mul_sum, acc_q[31:1]};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            if (is_div_q) begin
               lo_d = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
               hi_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
            end else begin
               {hi_d, lo_d} = neg_res_q ? w_prod_neg : acc_q;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         mcand_q   <= 32'd0;
         acc_q     <= 64'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_32b.sv
`default_nettype none
// ============================================================================
// tb_muldiv_32b : directed self-checking bench for muldiv_32b
// Revision      : 1.0
// ============================================================================
module tb_muldiv_32b;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;

   int pass_cnt  = 0;
   int total_cnt = 0;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   muldiv_32b dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents a request before the edge; returns 1ns after the accepting edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts edges until done is seen (bounded) and cycles with busy high.
   task automatic wait_done(output int lat, output int busy_cyc);
      lat = 0;
      busy_cyc = busy ? 1 : 0;
      while (lat < 100) begin
         @(posedge clk);
         #1 lat++;
         if (done) break;
         if (busy) busy_cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
      #12;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
      total_cnt++; if (HI !== 32'd0) $display("FAIL reset_hi: got %h expected 0", HI); else pass_cnt++;
      total_cnt++; if (LO !== 32'd0) $display("FAIL reset_lo: got %h expected 0", LO); else pass_cnt++;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_multu();
      int lat, bc;
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(lat, bc);
      total_cnt++; if (lat !== 33) $display("FAIL multu_latency: got %0d expected 33", lat); else pass_cnt++;
      total_cnt++; if (bc !== 33) $display("FAIL multu_busy_cycles: got %0d expected 33", bc); else pass_cnt++;
      total_cnt++; if (HI !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h expected fffffffe", HI); else pass_cnt++;
      total_cnt++; if (LO !== 32'h00000001) $display("FAIL multu_lo: got %h expected 00000001", LO); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (done !== 1'b0) $display("FAIL multu_done_width: got %b expected 0", done); else pass_cnt++;
   endtask

   task automatic test_mult();
      int lat, bc;
      issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
      wait_done(lat, bc);
      total_cnt++; if (HI !== 32'hFFFFFFFF) $display("FAIL mult_neg_hi: got %h expected ffffffff", HI); else pass_cnt++;
      total_cnt++; if (LO !== 32'hFFFFFFF1) $display("FAIL mult_neg_lo: got %h expected fffffff1", LO); else pass_cnt++;
      issue(OP_MULT, 32'h80000000, 32'h80000000);
      wait_done(lat, bc);
      total_cnt++; if (HI !== 32'h40000000) $display("FAIL mult_min_hi: got %h expected 40000000", HI); else pass_cnt++;
      total_cnt++; if (LO !== 32'h00000000) $display("FAIL mult_min_lo: got %h expected 00000000", LO); else pass_cnt++;
   endtask

   task automatic test_div();
      int lat, bc;
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_done(lat, bc);
      total_cnt++; if (LO !== 32'h0000000E) $display("FAIL divu_lo: got %h expected 0000000e", LO); else pass_cnt++;
      total_cnt++; if (HI !== 32'h00000002) $display("FAIL divu_hi: got %h expected 00000002", HI); else pass_cnt++;
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
      wait_done(lat, bc);
      total_cnt++; if (LO !== 32'hFFFFFFFD) $display("FAIL div_negdvd_lo: got %h expected fffffffd", LO); else pass_cnt++;
      total_cnt++; if (HI !== 32'hFFFFFFFF) $display("FAIL div_negdvd_hi: got %h expected ffffffff", HI); else pass_cnt++;
      issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
      wait_done(lat, bc);
      total_cnt++; if (LO !== 32'hFFFFFFFD) $display("FAIL div_negdvs_lo: got %h expected fffffffd", LO); else pass_cnt++;
      total_cnt++; if (HI !== 32'h00000001) $display("FAIL div_negdvs_hi: got %h expected 00000001", HI); else pass_cnt++;
   endtask

   task automatic test_div_corner();
      int lat, bc;
      issue(OP_DIVU, 32'h00001234, 32'd0);
      wait_done(lat, bc);
      total_cnt++; if (lat !== 33) $display("FAIL divzero_latency: got %0d expected 33", lat); else pass_cnt++;
      total_cnt++; if (HI !== 32'h00001234) $display("FAIL divzero_hi: got %h expected 00001234", HI); else pass_cnt++;
      total_cnt++; if (LO !== 32'hFFFFFFFF) $display("FAIL divzero_lo: got %h expected ffffffff", LO); else pass_cnt++;
      issue(OP_DIV, 32'hFFFFFFF0, 32'd0);
      wait_done(lat, bc);
      total_cnt++; if (HI !== 32'hFFFFFFF0) $display("FAIL sdivzero_hi: got %h expected fffffff0", HI); else pass_cnt++;
      total_cnt++; if (LO !== 32'hFFFFFFFF) $display("FAIL sdivzero_lo: got %h expected ffffffff", LO); else pass_cnt++;
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_done(lat, bc);
      total_cnt++; if (LO !== 32'h80000000) $display("FAIL div_ovf_lo: got %h expected 80000000", LO); else pass_cnt++;
      total_cnt++; if (HI !== 32'h00000000) $display("FAIL div_ovf_hi: got %h expected 00000000", HI); else pass_cnt++;
   endtask

   task automatic test_ignored_start();
      int lat, bc;
      issue(OP_MULTU, 32'd3, 32'd4);
      repeat (9) @(posedge clk);
      #1 start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
      @(posedge clk);
      #1 start = 1'b0; A = 32'hDEADBEEF; B = 32'h12345678; op = OP_MULT;
      wait_done(lat, bc);
      total_cnt++; if (lat !== 23) $display("FAIL ignore_latency: got %0d expected 23", lat); else pass_cnt++;
      total_cnt++; if (HI !== 32'd0) $display("FAIL ignore_hi: got %h expected 00000000", HI); else pass_cnt++;
      total_cnt++; if (LO !== 32'd12) $display("FAIL ignore_lo: got %h expected 0000000c", LO); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      issue(OP_MULTU, 32'd9, 32'd9);
      wait_done(lat, bc);
      total_cnt++; if (LO !== 32'd81) $display("FAIL b2b_first_lo: got %h expected 00000051", LO); else pass_cnt++;
      // still inside the done cycle: request is taken at the next edge
      start = 1'b1; op = OP_DIV; A = 32'hFFFFFFF9; B = 32'd2;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat, bc);
      total_cnt++; if (lat !== 33) $display("FAIL b2b_latency: got %0d expected 33", lat); else pass_cnt++;
      total_cnt++; if (LO !== 32'hFFFFFFFD) $display("FAIL b2b_lo: got %h expected fffffffd", LO); else pass_cnt++;
      total_cnt++; if (HI !== 32'hFFFFFFFF) $display("FAIL b2b_hi: got %h expected ffffffff", HI); else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int lat, bc, pulses;
      issue(OP_MULTU, 32'd2, 32'd2);
      wait_done(lat, bc);
      total_cnt++; if (LO !== 32'd4) $display("FAIL abort_pre_lo: got %h expected 00000004", LO); else pass_cnt++;
      issue(OP_MULTU, 32'd5, 32'd5);
      repeat (15) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else pass_cnt++;
      total_cnt++; if (HI !== 32'd0) $display("FAIL abort_hi: got %h expected 00000000", HI); else pass_cnt++;
      total_cnt++; if (LO !== 32'd0) $display("FAIL abort_lo: got %h expected 00000000", LO); else pass_cnt++;
      @(negedge clk) rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (done || busy) pulses++;
      end
      total_cnt++; if (pulses !== 0) $display("FAIL abort_no_done: got %0d active cycles expected 0", pulses); else pass_cnt++;
      issue(OP_MULTU, 32'd6, 32'd7);
      wait_done(lat, bc);
      total_cnt++; if (LO !== 32'd42) $display("FAIL abort_post_lo: got %h expected 0000002a", LO); else pass_cnt++;
      total_cnt++; if (HI !== 32'd0) $display("FAIL abort_post_hi: got %h expected 00000000", HI); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_div_corner();
      test_ignored_start();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
